uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have port CLK, input, 1, sole receiver clock at PRESCALE x bit rate.
REQ-002 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port RX_IN, input, 1, serial line, idle high.
REQ-004 SHALL have port PAR_EN, input, 1, parity bit present in frame.
REQ-005 SHALL have port PRESCALE, input, 5, oversampling ratio; legal values are 8 and 16 only.
REQ-006 SHALL have port EDGE_COUNT, input, 5, edge count from the edge/bit counter (0 when disabled, else 1..PRESCALE).
REQ-007 SHALL have port BIT_COUNT, input, 4, frame bit index from the edge/bit counter; increments on EDGE_COUNT==PRESCALE.
REQ-008 SHALL have ports STRT_GLITCH, PAR_ERR and STP_ERR, each input, 1, checker results, valid from the cycle after the matching check strobe.
REQ-009 SHALL have port COUNTER_EN, output, 1, enable to the edge/bit counter.
REQ-010 SHALL have port DATA_SAMP_EN, output, 1, enable to the data sampler.
REQ-011 SHALL have ports STRT_CHK_EN, PAR_CHK_EN and STP_CHK_EN, each output, 1, single-cycle check strobes.
REQ-012 SHALL have port DESER_EN, output, 1, single-cycle shift strobe to the deserializer.
REQ-013 SHALL have port DATA_VALID, output, 1, single-cycle good-frame pulse.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP and CHECK, held in a registered state with combinational output decode.
REQ-015 Frame bit map SHALL be: BIT_COUNT 0 start; 1..8 data, LSB first; 9 parity when PAR_EN; last bit stop (9 without parity, 10 with parity).
REQ-016 SAMPLE_PT SHALL equal (PRESCALE>>1)+2 and is the EDGE_COUNT value at which the sampled bit is valid.
REQ-017 IDLE -> START SHALL occur when RX_IN==0; PAR_EN SHALL be latched on this transition and held for the whole frame.
REQ-018 COUNTER_EN and DATA_SAMP_EN SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE and CHECK.
REQ-019 In START, STRT_CHK_EN SHALL pulse when EDGE_COUNT==SAMPLE_PT.
REQ-020 In START, if STRT_GLITCH==1 when EDGE_COUNT==SAMPLE_PT+1, the FSM SHALL go to IDLE, which clears the counters.
REQ-021 START -> DATA SHALL occur when BIT_COUNT==0 and EDGE_COUNT==PRESCALE.
REQ-022 In DATA, DESER_EN SHALL pulse when EDGE_COUNT==SAMPLE_PT, giving exactly 8 pulses per frame.
REQ-023 DATA SHALL exit when BIT_COUNT==8 and EDGE_COUNT==PRESCALE: to PARITY if latched PAR_EN, else to STOP.
REQ-024 In PARITY, PAR_CHK_EN SHALL pulse at SAMPLE_PT; PARITY -> STOP SHALL occur when BIT_COUNT==9 and EDGE_COUNT==PRESCALE.
REQ-025 In STOP, STP_CHK_EN SHALL pulse at SAMPLE_PT; STOP -> CHECK SHALL occur at the last stop-bit edge (EDGE_COUNT==PRESCALE).
REQ-026 CHECK SHALL last one cycle; DATA_VALID SHALL equal !STP_ERR && !(latched PAR_EN && PAR_ERR).
REQ-027 CHECK -> START SHALL occur if RX_IN==0 (back-to-back frame), else CHECK -> IDLE.
REQ-028 Error frames SHALL be dropped silently: no DATA_VALID, no sticky flag.
REQ-029 Changes to PRESCALE or PAR_EN mid-frame SHALL NOT affect the current frame's sequencing, except that PRESCALE is used live and any mid-frame change is illegal.

Reset
REQ-030 Asserting RST SHALL force IDLE and drive every output to 0 immediately, mid-frame included.
REQ-031 After RST deasserts, no transition SHALL occur until RX_IN==0 is seen on a CLK rising edge.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the state enum and the constants DATA_BITS=8, START_IDX=0, PAR_IDX=9, STOP_IDX_NOPAR=9 and STOP_IDX_PAR=10.
REQ-033 The block SHALL be a flat FSM with no sub-module; the edge/bit counter, sampler, checkers and deserializer are sibling instances in the RX top.

Verification
REQ-034 PRESCALE=8, PAR_EN=0, frame 0xA5, stop=1 -> 8 DESER_EN pulses at EDGE_COUNT==6; one DATA_VALID pulse 80 cycles after start detect.
REQ-035 PRESCALE=16, PAR_EN=1, even parity correct -> PAR_CHK_EN at BIT_COUNT 9 / EDGE 10; DATA_VALID=1; with PAR_ERR forced to 1 -> DATA_VALID stays 0.
REQ-036 PRESCALE=8, RX_IN low for 2 cycles only -> STRT_GLITCH=1; FSM back to IDLE at EDGE 7; no DESER_EN pulses.
REQ-037 Stop bit sampled 0 (STP_ERR=1) -> no DATA_VALID; FSM passes through CHECK and, with RX_IN low, re-enters START.
REQ-038 Two back-to-back frames with no idle gap -> CHECK -> START directly; two DATA_VALID pulses.
REQ-039 RST asserted at BIT_COUNT 4 -> all outputs 0 asynchronously; next frame after release is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// UART receiver shared definitions: FSM state encoding, frame bit
// indices and the oversampling sample-point helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5
    } state_t;

    localparam int DATA_BITS      = 8;
    localparam int START_IDX      = 0;
    localparam int PAR_IDX        = 9;
    localparam int STOP_IDX_NOPAR = 9;
    localparam int STOP_IDX_PAR   = 10;

    // Edge count at which the oversampled bit is stable.
    function automatic logic [4:0] sample_pt(input logic [4:0] prescale);
        return (prescale >> 1) + 5'd2;
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: walks start/data/parity/stop bits using
// the sibling edge/bit counter and strobes sampler, checkers, deserializer.
// Ports:
//   CLK, RST (async, active high)      - clock at PRESCALE x bit rate
//   RX_IN, PAR_EN, PRESCALE            - line, parity enable, oversampling
//   EDGE_COUNT, BIT_COUNT              - position within frame
//   STRT_GLITCH, PAR_ERR, STP_ERR      - checker results
//   COUNTER_EN, DATA_SAMP_EN           - level enables
//   STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN, DESER_EN, DATA_VALID - pulses
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [4:0] PRESCALE,
    input  logic [4:0] EDGE_COUNT,
    input  logic [3:0] BIT_COUNT,
    input  logic       STRT_GLITCH,
    input  logic       PAR_ERR,
    input  logic       STP_ERR,
    output logic       COUNTER_EN,
    output logic       DATA_SAMP_EN,
    output logic       STRT_CHK_EN,
    output logic       PAR_CHK_EN,
    output logic       STP_CHK_EN,
    output logic       DESER_EN,
    output logic       DATA_VALID
);

    state_t     state;
    state_t     state_nxt;
    logic       par_en_q;
    logic       par_en_nxt;
    logic [4:0] samp_pt;
    logic [3:0] stop_idx;
    logic       at_samp;
    logic       at_glitch_chk;
    logic       at_last_edge;

    assign samp_pt       = sample_pt(PRESCALE);
    assign at_samp       = (EDGE_COUNT == samp_pt);
    assign at_glitch_chk = (EDGE_COUNT == samp_pt + 5'd1);
    assign at_last_edge  = (EDGE_COUNT == PRESCALE);

    // Frame length depends on the parity setting captured at start.
    assign stop_idx = par_en_q ? 4'(STOP_IDX_PAR) : 4'(STOP_IDX_NOPAR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            par_en_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            par_en_q <= par_en_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        par_en_nxt   = par_en_q;
        COUNTER_EN   = 1'b0;
        DATA_SAMP_EN = 1'b0;
        STRT_CHK_EN  = 1'b0;
        PAR_CHK_EN   = 1'b0;
        STP_CHK_EN   = 1'b0;
        DESER_EN     = 1'b0;
        DATA_VALID   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt  = START;
                    par_en_nxt = PAR_EN;
                end
            end

            START: begin
                COUNTER_EN   = 1'b1;
                DATA_SAMP_EN = 1'b1;
                STRT_CHK_EN  = at_samp;
                // Glitch result is registered, so look one edge later.
                if (at_glitch_chk && STRT_GLITCH) begin
                    state_nxt = IDLE;
                end else if (BIT_COUNT == 4'(START_IDX) && at_last_edge) begin
                    state_nxt = DATA;
                end
            end

            DATA: begin
                COUNTER_EN   = 1'b1;
                DATA_SAMP_EN = 1'b1;
                DESER_EN     = at_samp;
                if (BIT_COUNT == 4'(DATA_BITS) && at_last_edge) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end

            PARITY: begin
                COUNTER_EN   = 1'b1;
                DATA_SAMP_EN = 1'b1;
                PAR_CHK_EN   = at_samp;
                if (BIT_COUNT == 4'(PAR_IDX) && at_last_edge) begin
                    state_nxt = STOP;
                end
            end

            STOP: begin
                COUNTER_EN   = 1'b1;
                DATA_SAMP_EN = 1'b1;
                STP_CHK_EN   = at_samp;
                if (BIT_COUNT == stop_idx && at_last_edge) begin
                    state_nxt = CHECK;
                end
            end

            CHECK: begin
                DATA_VALID = !STP_ERR && !(par_en_q && PAR_ERR);
                if (!RX_IN) begin
                    state_nxt  = START;
                    par_en_nxt = PAR_EN;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: models the edge/bit counter, checkers
// and deserializer around the FSM and drives hand-built serial frames.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [4:0] PRESCALE = 5'd8;
    logic [4:0] EDGE_COUNT;
    logic [3:0] BIT_COUNT;
    logic       STRT_GLITCH;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       COUNTER_EN;
    logic       DATA_SAMP_EN;
    logic       STRT_CHK_EN;
    logic       PAR_CHK_EN;
    logic       STP_CHK_EN;
    logic       DESER_EN;
    logic       DATA_VALID;

    uart_rx_fsm dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PRESCALE     (PRESCALE),
        .EDGE_COUNT   (EDGE_COUNT),
        .BIT_COUNT    (BIT_COUNT),
        .STRT_GLITCH  (STRT_GLITCH),
        .PAR_ERR      (PAR_ERR),
        .STP_ERR      (STP_ERR),
        .COUNTER_EN   (COUNTER_EN),
        .DATA_SAMP_EN (DATA_SAMP_EN),
        .STRT_CHK_EN  (STRT_CHK_EN),
        .PAR_CHK_EN   (PAR_CHK_EN),
        .STP_CHK_EN   (STP_CHK_EN),
        .DESER_EN     (DESER_EN),
        .DATA_VALID   (DATA_VALID)
    );

    always #5 CLK = ~CLK;

    // Edge/bit counter: EDGE_COUNT runs 1..PRESCALE while enabled.
    logic [4:0] cnt_q;
    logic [3:0] bit_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= 5'd0;
            bit_q <= 4'd0;
        end else if (!COUNTER_EN) begin
            cnt_q <= 5'd0;
            bit_q <= 4'd0;
        end else if (cnt_q + 5'd1 == PRESCALE) begin
            cnt_q <= 5'd0;
            bit_q <= bit_q + 4'd1;
        end else begin
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign EDGE_COUNT = COUNTER_EN ? cnt_q + 5'd1 : 5'd0;
    assign BIT_COUNT  = COUNTER_EN ? bit_q : 4'd0;

    // Checkers and deserializer (even parity).
    logic [7:0] shreg;
    logic       force_par = 1'b0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STRT_GLITCH <= 1'b0;
            PAR_ERR     <= 1'b0;
            STP_ERR     <= 1'b0;
            shreg       <= 8'd0;
        end else begin
            if (STRT_CHK_EN) STRT_GLITCH <= RX_IN;
            if (DESER_EN)    shreg <= {RX_IN, shreg[7:1]};
            if (PAR_CHK_EN)  PAR_ERR <= force_par | (RX_IN != ^shreg);
            if (STP_CHK_EN)  STP_ERR <= !RX_IN;
        end
    end

    // Monitor, sampled mid-cycle.
    int         cyc = 0;
    int         n_deser = 0;
    int         n_deser_bad = 0;
    int         n_dv = 0;
    int         n_strt = 0;
    int         n_par = 0;
    int         n_stp = 0;
    int         n_samp_bad = 0;
    int         start_cyc = 0;
    int         dv_cyc = 0;
    int         fall_cyc = 0;
    int         gap = 0;
    logic [7:0] dv_data = 8'd0;
    logic [3:0] par_bit = 4'd0;
    logic [4:0] par_edge = 5'd0;
    logic [4:0] exit_edge = 5'd0;
    logic [4:0] prev_edge = 5'd0;
    logic       prev_en = 1'b0;
    logic [4:0] exp_samp = 5'd6;
    logic [6:0] outs;

    assign outs = {COUNTER_EN, DATA_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN,
                   STP_CHK_EN, DESER_EN, DATA_VALID};

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DESER_EN) begin
            n_deser <= n_deser + 1;
            if (EDGE_COUNT != exp_samp) n_deser_bad <= n_deser_bad + 1;
        end
        if (DATA_VALID) begin
            n_dv    <= n_dv + 1;
            dv_cyc  <= cyc;
            dv_data <= shreg;
        end
        if (STRT_CHK_EN) n_strt <= n_strt + 1;
        if (STP_CHK_EN)  n_stp <= n_stp + 1;
        if (PAR_CHK_EN) begin
            n_par    <= n_par + 1;
            par_bit  <= BIT_COUNT;
            par_edge <= EDGE_COUNT;
        end
        if (DATA_SAMP_EN != COUNTER_EN) n_samp_bad <= n_samp_bad + 1;
        if (COUNTER_EN && !prev_en) begin
            start_cyc <= cyc;
            gap       <= cyc - fall_cyc;
        end
        if (!COUNTER_EN && prev_en) begin
            fall_cyc  <= cyc;
            exit_edge <= prev_edge;
        end
        prev_en   <= COUNTER_EN;
        prev_edge <= EDGE_COUNT;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int b_deser, b_deser_bad, b_dv, b_strt, b_par, b_stp;

    task automatic snap();
        b_deser     = n_deser;
        b_deser_bad = n_deser_bad;
        b_dv        = n_dv;
        b_strt      = n_strt;
        b_par       = n_par;
        b_stp       = n_stp;
    endtask

    // Caller is at a falling edge; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input bit par,
                              input bit stop);
        int n;
        n = par ? 11 : 10;
        for (int i = 0; i < n; i++) begin
            logic b;
            if (i == 0)             b = 1'b0;
            else if (i <= 8)        b = d[i-1];
            else if (par && i == 9) b = ^d;
            else                    b = stop;
            RX_IN = b;
            repeat (PRESCALE) @(negedge CLK);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        bit found;
        #1 RST = 1'b1;
        #11;
        chk("rst_outs", 32'(outs), 32'h0);
        @(negedge CLK) RST = 1'b0;
        idle(10);
        chk("idle_hold", 32'(COUNTER_EN), 32'h0);

        // 8x, no parity, 0xA5
        exp_samp = 5'd6;
        snap();
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(5);
        chk("a5_deser", n_deser - b_deser, 8);
        chk("a5_deser_edge", n_deser_bad - b_deser_bad, 0);
        chk("a5_dv", n_dv - b_dv, 1);
        chk("a5_data", 32'(dv_data), 32'hA5);
        chk("a5_lat", dv_cyc - start_cyc, 80);
        chk("a5_par", n_par - b_par, 0);
        chk("a5_stp", n_stp - b_stp, 1);

        // 16x, parity, good
        PRESCALE = 5'd16;
        PAR_EN   = 1'b1;
        exp_samp = 5'd10;
        snap();
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(5);
        chk("p16_dv", n_dv - b_dv, 1);
        chk("p16_data", 32'(dv_data), 32'h3C);
        chk("p16_par", n_par - b_par, 1);
        chk("p16_par_bit", 32'(par_bit), 9);
        chk("p16_par_edge", 32'(par_edge), 10);
        chk("p16_lat", dv_cyc - start_cyc, 176);
        chk("p16_deser_edge", n_deser_bad - b_deser_bad, 0);

        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        chk("p16_odd_dv", n_dv - b_dv, 1);
        chk("p16_odd_data", 32'(dv_data), 32'h07);

        force_par = 1'b1;
        snap();
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(5);
        force_par = 1'b0;
        chk("p16_perr_dv", n_dv - b_dv, 0);
        chk("p16_perr_par", n_par - b_par, 1);

        // start glitch
        PRESCALE = 5'd8;
        PAR_EN   = 1'b0;
        exp_samp = 5'd6;
        snap();
        RX_IN = 1'b0;
        idle(2);
        RX_IN = 1'b1;
        idle(20);
        chk("glitch_exit_edge", 32'(exit_edge), 7);
        chk("glitch_deser", n_deser - b_deser, 0);
        chk("glitch_dv", n_dv - b_dv, 0);
        chk("glitch_strt", n_strt - b_strt, 1);

        // stop error, line held low into the next frame
        snap();
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(5);
        chk("serr_dv", n_dv - b_dv, 1);
        chk("serr_data", 32'(dv_data), 32'hC3);
        chk("serr_gap", gap, 1);
        chk("serr_stp", n_stp - b_stp, 2);

        // back-to-back good frames
        snap();
        send_frame(8'h81, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1);
        idle(5);
        chk("b2b_dv", n_dv - b_dv, 2);
        chk("b2b_data", 32'(dv_data), 32'h7E);
        chk("b2b_gap", gap, 1);
        chk("b2b_deser", n_deser - b_deser, 16);

        // PAR_EN dropped mid-frame
        PAR_EN = 1'b1;
        snap();
        fork
            send_frame(8'h96, 1'b1, 1'b1);
            begin
                idle(30);
                PAR_EN = 1'b0;
            end
        join
        idle(5);
        chk("paren_mid_dv", n_dv - b_dv, 1);
        chk("paren_mid_par", n_par - b_par, 1);
        chk("paren_mid_data", 32'(dv_data), 32'h96);

        // reset mid-frame
        found = 1'b0;
        fork
            send_frame(8'hF0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 100 && !found; i++) begin
                    @(negedge CLK);
                    if (BIT_COUNT == 4'd4) found = 1'b1;
                end
                chk("rst_wait", 32'(found), 32'h1);
                chk("rst_pre_en", 32'(COUNTER_EN), 32'h1);
                #2 RST = 1'b1;
                #1;
                chk("rst_mid_outs", 32'(outs), 32'h0);
            end
        join
        @(negedge CLK) RST = 1'b0;
        idle(10);
        chk("rst_idle", 32'(COUNTER_EN), 32'h0);
        snap();
        send_frame(8'h4D, 1'b0, 1'b1);
        idle(5);
        chk("rst_next_dv", n_dv - b_dv, 1);
        chk("rst_next_data", 32'(dv_data), 32'h4D);
        chk("samp_en", n_samp_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
